// File: rtl/vga_pkg.sv
// Shared VGA timing constants, derived totals and count types for the timing
// generator and any renderer that needs to agree with it.
package vga_pkg;

    localparam int CNT_W = 11;
    localparam int DIV_W = 4;

    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;

    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int H_TOTAL      = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL      = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START = H_VIS_DEF + H_FP_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int V_SYNC_START = V_VIS_DEF + V_FP_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [DIV_W-1:0] div_t;

    // True when v lies in the inclusive window lo..hi.
    function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: raster position, blanking, syncs and pixel strobes.
interface vga_timing_gen_if;
    import vga_pkg::*;

    cnt_t hcount;
    cnt_t vcount;
    logic blank;
    logic hsync;
    logic vsync;
    logic pix_en;
    logic frame_start;

    modport master (
        output hcount, vcount, blank, hsync, vsync, pix_en, frame_start
    );

    modport slave (
        input hcount, vcount, blank, hsync, vsync, pix_en, frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis. Exposes the next value so
// the parent can register decoded flags in step with the count itself.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL = 800
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output cnt_t count,
    output cnt_t count_nxt,
    output logic tc
);

    localparam cnt_t LAST = cnt_t'(TOTAL - 1);

    assign tc = (count == LAST);

    // Advance on enable, wrap to zero after the last position.
    always_comb begin
        count_nxt = count;
        if (en) begin
            count_nxt = tc ? '0 : count + cnt_t'(1);
        end
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, horizontal/vertical counters and
// registered blank/sync/frame flags aligned with the counts they describe.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV = 4,
    parameter int H_VIS   = H_VIS_DEF,
    parameter int H_FP    = H_FP_DEF,
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BP    = H_BP_DEF,
    parameter int V_VIS   = V_VIS_DEF,
    parameter int V_FP    = V_FP_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BP    = V_BP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  vid
);

    localparam int   H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int   V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam cnt_t H_VIS_C  = cnt_t'(H_VIS);
    localparam cnt_t V_VIS_C  = cnt_t'(V_VIS);
    localparam cnt_t HS_START = cnt_t'(H_VIS + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_VIS + H_FP + H_SYNC - 1);
    localparam cnt_t VS_START = cnt_t'(V_VIS + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_VIS + V_FP + V_SYNC - 1);
    localparam div_t DIV_LAST = div_t'(PIX_DIV - 1);

    div_t div_q;
    logic tick;
    logic h_tc;
    logic v_tc;
    cnt_t h_nxt;
    cnt_t v_nxt;
    logic blank_nxt;
    logic hsync_nxt;
    logic vsync_nxt;

    // Pixel advance happens on the edge that closes the divider's last phase.
    assign tick = (div_q == DIV_LAST);

    vga_axis_counter #(.TOTAL(H_TOT)) u_hcnt (
        .clk       (clk),
        .rst       (rst),
        .en        (tick),
        .count     (vid.hcount),
        .count_nxt (h_nxt),
        .tc        (h_tc)
    );

    vga_axis_counter #(.TOTAL(V_TOT)) u_vcnt (
        .clk       (clk),
        .rst       (rst),
        .en        (tick & h_tc),
        .count     (vid.vcount),
        .count_nxt (v_nxt),
        .tc        (v_tc)
    );

    // Decode flags from the next position so the registered flags line up
    // with the registered counts.
    always_comb begin
        blank_nxt = (h_nxt >= H_VIS_C) || (v_nxt >= V_VIS_C);
        hsync_nxt = ~in_window(h_nxt, HS_START, HS_END);
        vsync_nxt = ~in_window(v_nxt, VS_START, VS_END);
    end

    // Divider phase and registered strobes/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q           <= '0;
            vid.pix_en      <= 1'b0;
            vid.frame_start <= 1'b0;
            vid.blank       <= 1'b0;
            vid.hsync       <= 1'b1;
            vid.vsync       <= 1'b1;
        end else begin
            div_q           <= tick ? '0 : div_q + div_t'(1);
            vid.pix_en      <= tick;
            vid.frame_start <= tick & h_tc & v_tc;
            vid.blank       <= blank_nxt;
            vid.hsync       <= hsync_nxt;
            vid.vsync       <= vsync_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480 timing, a small
// raster with PIX_DIV=3 and the same raster with PIX_DIV=1) checked every
// clock against a model that derives position from elapsed clocks.
module tb_vga_timing_gen;

    logic clk;
    logic rst_def;
    logic rst_sml;
    logic rst_d1;

    int t_def;
    int t_sml;
    int t_d1;

    int n_checks;
    int n_fail;
    bit run_chk;
    bit phase1;

    int hs_low_def;
    int vis_sml;
    int fs_d1;

    localparam int S_HV = 16, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VV = 8,  S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int S_FRAME_PIX = (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);
    localparam int P1_CYCLES = 7000;

    vga_timing_gen_if if_def ();
    vga_timing_gen_if if_sml ();
    vga_timing_gen_if if_d1 ();

    vga_timing_gen u_def (
        .clk (clk),
        .rst (rst_def),
        .vid (if_def)
    );

    vga_timing_gen #(
        .PIX_DIV(3),
        .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_sml (
        .clk (clk),
        .rst (rst_sml),
        .vid (if_sml)
    );

    vga_timing_gen #(
        .PIX_DIV(1),
        .H_VIS(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_d1 (
        .clk (clk),
        .rst (rst_d1),
        .vid (if_d1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: t clocks since reset release give t/pd pixel advances; the
    // raster position is that pixel count modulo the frame size.
    task automatic model(input int t, input int pd,
                         input int hv, input int hf, input int hs, input int hb,
                         input int vv, input int vf, input int vs, input int vb,
                         output int hc, output int vc, output int bl,
                         output int hsy, output int vsy, output int pe, output int fs);
        int ht, vt, pos;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        if (t == 0) begin
            hc = 0; vc = 0; bl = 0; hsy = 1; vsy = 1; pe = 0; fs = 0;
        end else begin
            pos = (t / pd) % (ht * vt);
            hc  = pos % ht;
            vc  = pos / ht;
            pe  = (t % pd == 0) ? 1 : 0;
            fs  = (pe == 1 && pos == 0) ? 1 : 0;
            bl  = (hc >= hv || vc >= vv) ? 1 : 0;
            hsy = (hc >= hv + hf && hc < hv + hf + hs) ? 0 : 1;
            vsy = (vc >= vv + vf && vc < vv + vf + vs) ? 0 : 1;
        end
    endtask

    task automatic check_unit(input string nm, input int t, input int pd,
                              input int hv, input int hf, input int hs, input int hb,
                              input int vv, input int vf, input int vs, input int vb,
                              input int o_hc, input int o_vc, input int o_bl,
                              input int o_hsy, input int o_vsy, input int o_pe, input int o_fs);
        int hc, vc, bl, hsy, vsy, pe, fs;
        model(t, pd, hv, hf, hs, hb, vv, vf, vs, vb, hc, vc, bl, hsy, vsy, pe, fs);
        chk($sformatf("%s hcount t=%0d", nm, t), o_hc, hc);
        chk($sformatf("%s vcount t=%0d", nm, t), o_vc, vc);
        chk($sformatf("%s blank t=%0d", nm, t), o_bl, bl);
        chk($sformatf("%s hsync t=%0d", nm, t), o_hsy, hsy);
        chk($sformatf("%s vsync t=%0d", nm, t), o_vsy, vsy);
        chk($sformatf("%s pix_en t=%0d", nm, t), o_pe, pe);
        chk($sformatf("%s frame_start t=%0d", nm, t), o_fs, fs);
    endtask

    // Clocks since last reset, as seen by each instance.
    always @(posedge clk) begin
        t_def <= rst_def ? 0 : t_def + 1;
        t_sml <= rst_sml ? 0 : t_sml + 1;
        t_d1  <= rst_d1  ? 0 : t_d1 + 1;
    end

    // Per-clock comparison against the model, sampled mid-period.
    always @(negedge clk) begin
        if (run_chk) begin
            check_unit("def", t_def, 4, 640, 16, 96, 48, 480, 10, 2, 33,
                       int'(if_def.hcount), int'(if_def.vcount), int'(if_def.blank),
                       int'(if_def.hsync), int'(if_def.vsync), int'(if_def.pix_en),
                       int'(if_def.frame_start));
            check_unit("sml", t_sml, 3, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB,
                       int'(if_sml.hcount), int'(if_sml.vcount), int'(if_sml.blank),
                       int'(if_sml.hsync), int'(if_sml.vsync), int'(if_sml.pix_en),
                       int'(if_sml.frame_start));
            check_unit("d1", t_d1, 1, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB,
                       int'(if_d1.hcount), int'(if_d1.vcount), int'(if_d1.blank),
                       int'(if_d1.hsync), int'(if_d1.vsync), int'(if_d1.pix_en),
                       int'(if_d1.frame_start));
            if (phase1) begin
                if (t_def >= 1 && t_def <= 3200 && if_def.pix_en && !if_def.hsync)
                    hs_low_def++;
                if (t_sml >= 1 && t_sml <= 3 * S_FRAME_PIX && if_sml.pix_en && !if_sml.blank)
                    vis_sml++;
                if (if_d1.frame_start)
                    fs_d1++;
            end
        end
    end

    initial begin
        logic [2:0] sel;
        int gap;
        int len;

        n_checks   = 0;
        n_fail     = 0;
        run_chk    = 0;
        phase1     = 0;
        hs_low_def = 0;
        vis_sml    = 0;
        fs_d1      = 0;
        t_def      = 0;
        t_sml      = 0;
        t_d1       = 0;
        rst_def    = 1'b1;
        rst_sml    = 1'b1;
        rst_d1     = 1'b1;

        repeat (2) @(negedge clk);
        run_chk = 1;
        @(negedge clk);
        rst_def = 1'b0;
        rst_sml = 1'b0;
        rst_d1  = 1'b0;
        phase1  = 1;

        repeat (P1_CYCLES) @(negedge clk);
        phase1 = 0;
        chk("def hsync low pixels in first line", hs_low_def, 96);
        chk("sml visible pixels in first frame", vis_sml, S_VV * S_HV);
        chk("d1 frame_start pulses", fs_d1, P1_CYCLES / S_FRAME_PIX);

        // Random mid-frame resets on random subsets of the instances.
        for (int i = 0; i < 30; i++) begin
            gap = $urandom_range(1, 600);
            repeat (gap) @(negedge clk);
            sel = 3'($urandom_range(1, 7));
            len = $urandom_range(1, 3);
            rst_def = sel[0];
            rst_sml = sel[1];
            rst_d1  = sel[2];
            repeat (len) @(negedge clk);
            rst_def = 1'b0;
            rst_sml = 1'b0;
            rst_d1  = 1'b0;
        end

        repeat (1000) @(negedge clk);
        run_chk = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
